// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared definitions for alu_cmd_sequencer: command opcodes, ALU control
// encodings and FSM states.
package alu_cmd_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_AND  = 2'b11
    } op_e;

    localparam logic [1:0] CTRL_AND = 2'b00;
    localparam logic [1:0] CTRL_ADD = 2'b01;
    localparam logic [1:0] CTRL_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

    // Map an arithmetic/logic command onto the ALU ctrl encoding.
    function automatic logic [1:0] op_to_ctrl(input op_e op);
        case (op)
            OP_ADD:  return CTRL_ADD;
            OP_SUB:  return CTRL_SUB;
            default: return CTRL_AND;
        endcase
    endfunction

endpackage

// File: rtl/alu_sat_clamp.sv
// Saturating clamp for a signed ALU result: on overflow, pin to +max when
// operand A was non-negative, otherwise to -min.
module alu_sat_clamp #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] result,
    input  logic             ovf,
    input  logic             a_msb,
    output logic [WIDTH-1:0] clamped
);

    // Select wrapped result or the saturation bound.
    always_comb begin
        clamped = result;
        if (ovf) begin
            clamped = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for an external combinational WIDTH-bit ALU. Accepts accumulator
// commands on a valid/ready channel, drives registered operands/ctrl, captures
// the ALU result and returns acc + overflow flags on a response channel.
// Optional build macro: ALU_SAT_EN (saturate acc on ADD/SUB overflow).
module alu_cmd_sequencer
    import alu_cmd_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_operand,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_acc,
    output logic             rsp_ovf,
    output logic             sticky_ovf,
    output logic [WIDTH-1:0] alu_opA,
    output logic [WIDTH-1:0] alu_opB,
    output logic [1:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow
);

    state_e           state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [1:0]       ctrl_q;
    logic             ovf_q;
    logic             sticky_q;
    logic [WIDTH-1:0] acc_exec_d;
    op_e              cmd_op_e;

    assign cmd_op_e = op_e'(cmd_op);

`ifdef ALU_SAT_EN
    alu_sat_clamp #(
        .WIDTH(WIDTH)
    ) u_sat_clamp (
        .result  (alu_result),
        .ovf     (alu_overflow && (ctrl_q != CTRL_AND)),
        .a_msb   (opa_q[WIDTH-1]),
        .clamped (acc_exec_d)
    );
`else
    assign acc_exec_d = alu_result;
`endif

    // Command FSM: IDLE accepts, EXEC captures the ALU for one cycle, RESP waits for the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            ctrl_q   <= CTRL_AND;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op_e == OP_LOAD) begin
                            acc_q    <= cmd_operand;
                            ovf_q    <= 1'b0;
                            sticky_q <= 1'b0;
                            state_q  <= S_RESP;
                        end else begin
                            opa_q   <= acc_q;
                            opb_q   <= cmd_operand;
                            ctrl_q  <= op_to_ctrl(cmd_op_e);
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    acc_q    <= acc_exec_d;
                    ovf_q    <= alu_overflow;
                    sticky_q <= sticky_q | alu_overflow;
                    state_q  <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_acc    = acc_q;
    assign rsp_ovf    = ovf_q;
    assign sticky_ovf = sticky_q;
    assign alu_opA    = opa_q;
    assign alu_opB    = opb_q;
    assign alu_ctrl   = ctrl_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural four-bit ALU
// and a transaction-level accumulator model. Honours ALU_SAT_EN.
module tb_alu_cmd_sequencer;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_operand;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_acc;
    logic             rsp_ovf;
    logic             sticky_ovf;
    logic [WIDTH-1:0] alu_opA;
    logic [WIDTH-1:0] alu_opB;
    logic [1:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_overflow;

    int n_vec = 0;
    int n_err = 0;

    // Accumulator-level reference state
    int acc_m;
    int sticky_m;
    int ovf_m;
    int opa_m;
    int opb_m;
    int ctrl_m;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_operand  (cmd_operand),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_acc      (rsp_acc),
        .rsp_ovf      (rsp_ovf),
        .sticky_ovf   (sticky_ovf),
        .alu_opA      (alu_opA),
        .alu_opB      (alu_opB),
        .alu_ctrl     (alu_ctrl),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow)
    );

    // Behavioural four-bit ALU: signed arithmetic, overflow when out of [-8,7].
    always_comb begin
        int sa;
        int sb;
        int r;
        sa = (alu_opA >= 4'd8) ? int'(alu_opA) - 16 : int'(alu_opA);
        sb = (alu_opB >= 4'd8) ? int'(alu_opB) - 16 : int'(alu_opB);
        r  = 0;
        alu_overflow = 1'b0;
        case (alu_ctrl)
            2'b01: begin r = sa + sb; alu_overflow = (r > 7) || (r < -8); end
            2'b11: begin r = sa - sb; alu_overflow = (r > 7) || (r < -8); end
            2'b00: r = int'(alu_opA & alu_opB);
            default: r = 0;
        endcase
        alu_result = r[3:0];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int to_signed4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    // Apply one command, then hold the response for 'hold' extra cycles before consuming it.
    task automatic do_cmd(input int op, input int opnd, input int hold);
        int a;
        int res;
        int ovf;
        check_eq("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_op      = 2'(op);
        cmd_operand = 4'(opnd);
        rsp_ready   = 1'($urandom_range(0, 1));  // must be ignored while idle
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_op      = 2'($urandom);
        cmd_operand = 4'($urandom);
        rsp_ready   = 1'b0;
        if (op == 0) begin
            acc_m    = opnd;
            ovf_m    = 0;
            sticky_m = 0;
        end else begin
            a     = acc_m;
            opa_m = a;
            opb_m = opnd;
            case (op)
                1: begin res = to_signed4(a) + to_signed4(opnd); ctrl_m = 1; end
                2: begin res = to_signed4(a) - to_signed4(opnd); ctrl_m = 3; end
                default: begin res = a & opnd; ctrl_m = 0; end
            endcase
            ovf = (op != 3 && (res > 7 || res < -8)) ? 1 : 0;
            acc_m = res & 15;
`ifdef ALU_SAT_EN
            if (ovf == 1) acc_m = (a >= 8) ? 8 : 7;
`endif
            ovf_m    = ovf;
            sticky_m = sticky_m | ovf;
            check_eq("exec_rsp_valid", 32'(rsp_valid), 32'd0);
            check_eq("exec_cmd_ready", 32'(cmd_ready), 32'd0);
            check_eq("exec_alu_ctrl", 32'(alu_ctrl), 32'(ctrl_m));
            check_eq("exec_alu_opA", 32'(alu_opA), 32'(opa_m));
            check_eq("exec_alu_opB", 32'(alu_opB), 32'(opb_m));
            @(negedge clk);
        end
        check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("rsp_acc", 32'(rsp_acc), 32'(acc_m));
        check_eq("rsp_ovf", 32'(rsp_ovf), 32'(ovf_m));
        check_eq("sticky_ovf", 32'(sticky_ovf), 32'(sticky_m));
        check_eq("resp_alu_opA_hold", 32'(alu_opA), 32'(opa_m));
        check_eq("resp_alu_ctrl_hold", 32'(alu_ctrl), 32'(ctrl_m));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_rsp_acc", 32'(rsp_acc), 32'(acc_m));
            check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_rsp_acc_hold", 32'(rsp_acc), 32'(acc_m));
        check_eq("post_rsp_ovf_hold", 32'(rsp_ovf), 32'(ovf_m));
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_acc"}, 32'(rsp_acc), 32'd0);
        check_eq({tag, "_ovf"}, 32'(rsp_ovf), 32'd0);
        check_eq({tag, "_sticky"}, 32'(sticky_ovf), 32'd0);
        check_eq({tag, "_opA"}, 32'(alu_opA), 32'd0);
        check_eq({tag, "_opB"}, 32'(alu_opB), 32'd0);
        check_eq({tag, "_ctrl"}, 32'(alu_ctrl), 32'd0);
    endtask

    task automatic model_reset();
        acc_m = 0; sticky_m = 0; ovf_m = 0; opa_m = 0; opb_m = 0; ctrl_m = 0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_operand = '0; rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // Directed scenarios
        do_cmd(0, 3, 0); do_cmd(1, 2, 0);
        check_eq("t1_acc", 32'(rsp_acc), 32'd5);
        do_cmd(0, 7, 0); do_cmd(1, 1, 0);
        check_eq("t2_ovf", 32'(rsp_ovf), 32'd1);
`ifdef ALU_SAT_EN
        check_eq("t2_acc", 32'(rsp_acc), 32'd7);
`else
        check_eq("t2_acc", 32'(rsp_acc), 32'd8);
`endif
        do_cmd(0, 8, 0); do_cmd(2, 1, 0);
`ifdef ALU_SAT_EN
        check_eq("t3_acc", 32'(rsp_acc), 32'd8);
`else
        check_eq("t3_acc", 32'(rsp_acc), 32'd7);
`endif
        do_cmd(3, 15, 0);
        check_eq("t3_and_ovf", 32'(rsp_ovf), 32'd0);
        check_eq("t3_sticky", 32'(sticky_ovf), 32'd1);
        do_cmd(0, 12, 0); do_cmd(3, 6, 0);
        check_eq("t4_acc", 32'(rsp_acc), 32'd4);
        do_cmd(0, 0, 0);
        check_eq("t4_sticky_clr", 32'(sticky_ovf), 32'd0);
        do_cmd(1, 5, 5);

        // Randomized command stream
        for (int n = 0; n < 300; n++) begin
            do_cmd(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)));
        end

        // Asynchronous reset while an ALU op is executing
        do_cmd(0, 9, 0);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_operand = 4'd3;
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_reset_state("async_rst");
        @(negedge clk);
        check_reset_state("rst_exec");
        rst = 1'b0;
        @(negedge clk);
        do_cmd(1, 4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
